// File: rtl/btb_predictor_if.sv
// Fetch/decode-side bundle for the branch target buffer: lookup, resolved update and statistics.
// The BTB connects through the slave modport; the pipeline drives it through the master modport.
interface btb_predictor_if #(
  parameter int CNT_BITS = 16
);
  logic                LookupEn;
  logic [31:0]         PC;
  logic                Hit;
  logic                Prediction;
  logic [31:0]         PredictedTarget;
  logic                UpdateEnable;
  logic [31:0]         PCUpdate;
  logic                BranchTaken;
  logic [31:0]         PCBranch;
  logic                UpdateMispredict;
  logic                Invalidate;
  logic [CNT_BITS-1:0] MispredictCount;

  modport master (
    output LookupEn, PC, UpdateEnable, PCUpdate, BranchTaken, PCBranch,
           UpdateMispredict, Invalidate,
    input  Hit, Prediction, PredictedTarget, MispredictCount
  );

  modport slave (
    input  LookupEn, PC, UpdateEnable, PCUpdate, BranchTaken, PCBranch,
           UpdateMispredict, Invalidate,
    output Hit, Prediction, PredictedTarget, MispredictCount
  );
endinterface

// File: rtl/btb_predictor.sv
// Tagged branch target buffer with saturating direction counters, taken-only allocation,
// bulk invalidate and a saturating mispredict statistic. Lookup is same-cycle combinational.
module btb_predictor #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int CNT_BITS = 16
) (
  input  logic           clk,
  input  logic           reset,
  btb_predictor_if.slave bus
);
  localparam int IDX = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [31:0] FIELD_MASK = ((32'(1) << (IDX + TAG_BITS)) - 32'(1)) << 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [IDX-1:0]      lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  logic                lk_hit, upd_hit, upd_go;
  logic                wr_en, alloc;
  logic [CTR_BITS-1:0] ctr_d;
  logic [31:0]         target_d;
  logic [31:0]         unused_pc_bits, unused_upd_bits;

  assign unused_pc_bits  = bus.PC & ~FIELD_MASK;
  assign unused_upd_bits = bus.PCUpdate & ~FIELD_MASK;

  // Lookup reads pre-edge state only; no bypass from a same-cycle update.
  assign lk_idx = bus.PC[IDX+1:2];
  assign lk_tag = bus.PC[IDX+1+TAG_BITS:IDX+2];
  assign lk_hit = bus.LookupEn & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign bus.Hit             = lk_hit;
  assign bus.Prediction      = lk_hit & ctr_q[lk_idx][CTR_BITS-1];
  assign bus.PredictedTarget = lk_hit ? target_q[lk_idx] : 32'h0;
  assign bus.MispredictCount = cnt_q;

  assign upd_idx = bus.PCUpdate[IDX+1:2];
  assign upd_tag = bus.PCUpdate[IDX+1+TAG_BITS:IDX+2];
  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_go  = bus.UpdateEnable & ~bus.Invalidate;

  always_comb begin
    wr_en    = 1'b0;
    alloc    = 1'b0;
    ctr_d    = ctr_q[upd_idx];
    target_d = target_q[upd_idx];
    if (upd_go) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.BranchTaken) begin
          ctr_d    = (ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_BITS'(1);
          target_d = bus.PCBranch;
        end else begin
          ctr_d = (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_BITS'(1);
        end
      end else if (bus.BranchTaken) begin
        // A taken miss evicts whatever aliased into this slot.
        wr_en    = 1'b1;
        alloc    = 1'b1;
        ctr_d    = CTR_WT;
        target_d = bus.PCBranch;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.UpdateEnable && bus.UpdateMispredict && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      cnt_q <= cnt_d;
      if (bus.Invalidate) begin
        valid_q <= '0;
      end else if (alloc) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
      end
      if (wr_en) begin
        ctr_q[upd_idx]    <= ctr_d;
        target_q[upd_idx] <= target_d;
      end
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed, table-driven bench for btb_predictor with ENTRIES=64, TAG_BITS=8, CTR_BITS=2, CNT_BITS=4.
module tb_btb_predictor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  btb_predictor_if #(.CNT_BITS(4)) bus ();

  btb_predictor #(.ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .CNT_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        taken;
    logic [31:0] tgt;
    logic        mispred;
    logic        inval;
    logic        exp_hit;
    logic        exp_pred;
    logic [31:0] exp_tgt;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lk_en, input logic [31:0] lk_pc, input logic upd_en,
                     input logic [31:0] upd_pc, input logic taken, input logic [31:0] tgt,
                     input logic mispred, input logic inval, input logic exp_hit,
                     input logic exp_pred, input logic [31:0] exp_tgt, input logic [3:0] exp_cnt);
    vec_t v;
    v.lk_en = lk_en;   v.lk_pc = lk_pc;     v.upd_en = upd_en; v.upd_pc = upd_pc;
    v.taken = taken;   v.tgt = tgt;         v.mispred = mispred; v.inval = inval;
    v.exp_hit = exp_hit; v.exp_pred = exp_pred; v.exp_tgt = exp_tgt; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lk_en, input logic [31:0] lk_pc, input logic upd_en,
                       input logic [31:0] upd_pc, input logic taken, input logic [31:0] tgt,
                       input logic mispred, input logic inval);
    bus.LookupEn = lk_en;   bus.PC = lk_pc;
    bus.UpdateEnable = upd_en; bus.PCUpdate = upd_pc;
    bus.BranchTaken = taken;   bus.PCBranch = tgt;
    bus.UpdateMispredict = mispred; bus.Invalidate = inval;
  endtask

  task automatic chk_out(input string tag, input logic hit, input logic pred,
                         input logic [31:0] tgt, input logic [3:0] cnt);
    chk({tag, " hit"},  32'(bus.Hit), 32'(hit));
    chk({tag, " pred"}, 32'(bus.Prediction), 32'(pred));
    chk({tag, " tgt"},  bus.PredictedTarget, tgt);
    chk({tag, " cnt"},  32'(bus.MispredictCount), 32'(cnt));
  endtask

  initial begin
    //   lk  lk_pc   upd  upd_pc   tk tgt     mp inv  hit pr exp_tgt cnt
    add(1, 32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 0); // cold lookup
    add(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0,  0, 0, 32'h000, 0); // allocate
    add(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 0,  1, 1, 32'h200, 0); // ctr 2 -> 1
    add(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 0,  1, 0, 32'h200, 0); // 1 -> 0
    add(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 0,  1, 0, 32'h200, 0); // 0 -> 0
    add(1, 32'h100, 1, 32'h100, 1, 32'h240, 0, 0,  1, 0, 32'h200, 0); // 0 -> 1, new target
    add(1, 32'h100, 1, 32'h100, 1, 32'h240, 0, 0,  1, 0, 32'h240, 0); // 1 -> 2
    add(1, 32'h100, 1, 32'h100, 1, 32'h240, 0, 0,  1, 1, 32'h240, 0); // 2 -> 3
    add(1, 32'h100, 1, 32'h100, 1, 32'h240, 0, 0,  1, 1, 32'h240, 0); // 3 -> 3
    add(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 0,  1, 1, 32'h240, 0); // 3 -> 2
    add(1, 32'h100, 1, 32'h100, 0, 32'h000, 0, 0,  1, 1, 32'h240, 0); // 2 -> 1
    add(1, 32'h300, 1, 32'h300, 0, 32'h000, 0, 0,  0, 0, 32'h000, 0); // alias, NT miss
    add(1, 32'h100, 1, 32'h300, 1, 32'h400, 0, 0,  1, 0, 32'h240, 0); // alias evicts
    add(1, 32'h100, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 0);
    add(1, 32'h300, 0, 32'h000, 0, 32'h000, 0, 0,  1, 1, 32'h400, 0);
    add(0, 32'h300, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 0); // LookupEn low
    add(1, 32'h500, 1, 32'h500, 1, 32'h600, 0, 0,  0, 0, 32'h000, 0); // no bypass
    add(1, 32'h500, 1, 32'h700, 1, 32'h800, 1, 1,  1, 1, 32'h600, 0); // invalidate wins
    add(1, 32'h500, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 1);
    add(1, 32'h700, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 1);
    add(1, 32'h300, 0, 32'h000, 0, 32'h000, 0, 0,  0, 0, 32'h000, 1);

    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("in_reset", 0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].lk_en, vecs[i].lk_pc, vecs[i].upd_en, vecs[i].upd_pc,
            vecs[i].taken, vecs[i].tgt, vecs[i].mispred, vecs[i].inval);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].exp_hit, vecs[i].exp_pred,
              vecs[i].exp_tgt, vecs[i].exp_cnt);
    end

    // Mispredict statistic saturates at 15 after 20 further mispredicts (starting from 1).
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 32'h0, 1, 32'h1000, 0, 32'h0, 1, 0);
      @(negedge clk);
      drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      #1;
      chk($sformatf("sat%0d cnt", k), 32'(bus.MispredictCount), (k + 2 > 15) ? 32'd15 : 32'(k + 2));
    end

    // Allocate, then pull reset low between edges while an update is pending.
    @(negedge clk);
    drive(1, 32'hA00, 1, 32'hA00, 1, 32'hB00, 0, 0);
    @(negedge clk);
    drive(1, 32'hA00, 1, 32'hA00, 1, 32'hC00, 1, 0);
    #1;
    chk_out("pre_rst", 1, 1, 32'hB00, 15);
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'hA00, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("post_rst", 0, 0, 32'h0, 0);
    @(negedge clk);
    drive(1, 32'hA00, 1, 32'hA00, 0, 32'h0, 0, 0);
    #1;
    chk_out("post_rst2", 0, 0, 32'h0, 0);
    @(negedge clk);
    drive(1, 32'hA00, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("nt_no_alloc", 0, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised branch target buffer with tagged entries and per-entry saturating direction counters. Successor to the single-bit BTB in the fetch stage.
Fetch stage does a same-cycle combinational lookup on PCF. Decode stage writes resolved branch outcomes back on the clock edge.
New over the previous generation: tag matching, N-bit hysteresis counters, taken-only allocation, bulk invalidate and a saturating mispredict counter.

Parameters:
ENTRIES, 64, number of entries; power of 2, >= 2; IDX = log2(ENTRIES)
TAG_BITS, 8, stored tag width; 1 <= TAG_BITS <= 30-IDX
CTR_BITS, 2, direction counter width; >= 1
CNT_BITS, 16, mispredict statistic counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
LookupEn  in  1  qualifies lookup (fetched instruction is a branch)
PC  in  32  fetch address
Hit  out  1  valid entry with matching tag
Prediction  out  1  predicted taken
PredictedTarget  out  32  predicted target
UpdateEnable  in  1  write resolved branch this edge
PCUpdate  in  32  address of resolved branch
BranchTaken  in  1  resolved direction
PCBranch  in  32  resolved target
UpdateMispredict  in  1  resolved branch was mispredicted
Invalidate  in  1  clear all valid bits
MispredictCount  out  CNT_BITS  saturating mispredict count

Behaviour:
Address fields:
- idx = addr[IDX+1:2]
- tag = addr[IDX+1+TAG_BITS:IDX+2]

Reset (reset=0, asynchronous, takes effect immediately, including mid-update):
- All valid bits = 0, all targets = 0.
- All counters = weakly-not-taken, i.e. 2^(CTR_BITS-1)-1 (0 when CTR_BITS=1).
- MispredictCount = 0.
- Hence Hit = 0, Prediction = 0, PredictedTarget = 0.

Lookup (purely combinational, zero latency):
- Hit = LookupEn & valid[idx] & (tag[idx] == tag(PC)).
- Prediction = Hit & ctr[idx][CTR_BITS-1].
- PredictedTarget = Hit ? target[idx] : 0.

Update (rising edge, only when UpdateEnable=1 and Invalidate=0):
- Tag hit, taken: ctr = min(ctr+1, 2^CTR_BITS-1); target <= PCBranch.
- Tag hit, not taken: ctr = max(ctr-1, 0); target unchanged.
- Miss (invalid entry or tag mismatch), taken: allocate. valid=1, tag=tag(PCUpdate), target=PCBranch, ctr = 2^(CTR_BITS-1) (weakly taken). Any previous occupant is overwritten.
- Miss, not taken: no state change.

Simultaneous events:
- Lookup and update to the same idx in the same cycle: lookup sees pre-edge state. No write-to-read bypass.
- Invalidate=1: all valid bits cleared on the edge. Counters and targets are retained.
- Invalidate and UpdateEnable in the same cycle: Invalidate wins; the update is dropped. MispredictCount still counts.

MispredictCount:
- Increments on each edge with UpdateEnable & UpdateMispredict.
- Saturates at all-ones.
- Cleared only by reset.

No other state. No multi-cycle operations, no backpressure.

Test Plan:
Configuration: ENTRIES=64, TAG_BITS=8, CTR_BITS=2, CNT_BITS=4. idx=PC[7:2], tag=PC[15:8].

1. Reset/cold lookup: release reset, LookupEn=1, PC=0x100 -> Hit=0, Prediction=0, PredictedTarget=0. Assert reset=0 mid-run -> all three outputs drop to 0 before the next edge.
2. Allocation: update PCUpdate=0x100, taken, PCBranch=0x200. Next cycle lookup 0x100 -> Hit=1, Prediction=1, PredictedTarget=0x200 (ctr=2).
3. Hysteresis/saturation, from ctr=2 on 0x100:
   - not-taken x3 -> ctr 1, 0, 0; Prediction=0, Hit=1.
   - taken x1 -> ctr=1, Prediction=0.
   - taken x3 -> ctr 2, 3, 3; Prediction=1.
4. Aliasing: with 0x100 allocated, lookup 0x300 (same idx 0, tag 0x03) -> Hit=0.
   - Not-taken update of 0x300 -> lookup 0x100 still Hit=1.
   - Taken update of 0x300, target 0x400 -> lookup 0x100 Hit=0; lookup 0x300 Hit=1, target 0x400.
5. Same-cycle lookup and update on 0x500 (taken, target 0x600) -> Hit=0 that cycle, Hit=1 with target 0x600 next cycle.
6. Invalidate + UpdateEnable + UpdateMispredict in one cycle -> all lookups Hit=0 afterwards, no entry allocated, MispredictCount increments.
   - Then 20 further mispredict updates -> MispredictCount=15 (saturated).
